// File: rtl/caliptra_apb_initiator_pkg.sv
// Shared types for the Caliptra APB initiator.
//   apb_init_state_e : transfer sequencer states.
//   apb_cmd_t        : one queued APB command (direction, address, write data, PAUSER).
// Field widths follow the Caliptra SoC APB port (32-bit address, data and user).
package caliptra_apb_initiator_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_USER_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_init_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_USER_W-1:0] user;
  } apb_cmd_t;

endpackage

// File: rtl/caliptra_apb_cmd_fifo.sv
// Synchronous command FIFO.
//   clk_i, rst_ni      : clock, asynchronous active-low reset (pointers/count only).
//   push_i, wdata_i    : write an entry; ignored while full.
//   pop_i, rdata_o     : drop the head entry; ignored while empty. rdata_o shows the head.
//   full_o, empty_o    : occupancy flags.
//   count_o            : number of stored entries.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module caliptra_apb_cmd_fifo
  import caliptra_apb_initiator_pkg::*;
#(
  parameter type         T     = apb_cmd_t,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  T                 wdata_i,
  input  logic             pop_i,
  output T                 rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/caliptra_apb_initiator.sv
// APB requester driving the Caliptra SoC-facing APB slave port.
//   clk, cptra_rst_b           : clock, asynchronous active-low reset.
//   cmd_*                      : queued command input (valid/ready).
//   rsp_*                      : one response per transfer (valid/ready); rdata is 0 for
//                                writes and timeouts, err covers PSLVERR and timeout.
//   busy                       : commands queued or a transfer/response in flight.
//   paddr..pauser, pready..    : APB requester signals; pprot is always 0.
// One transfer is outstanding at a time: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
module caliptra_apb_initiator
  import caliptra_apb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned USER_W         = APB_USER_W,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              cptra_rst_b,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [USER_W-1:0] cmd_user,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic [2:0]        pprot,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [USER_W-1:0] pauser,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  localparam int unsigned CNT_W = $clog2(CMD_DEPTH + 1);
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  // Same layout as apb_cmd_t, sized by this instance's parameters.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [USER_W-1:0] user;
  } cmd_t;

  cmd_t             cmd_in, cmd_head;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0] fifo_cnt;

  apb_init_state_e   state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [USER_W-1:0] pauser_q, pauser_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              tout_q, tout_d;

  assign cmd_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, user: cmd_user};

  caliptra_apb_cmd_fifo #(
    .T     (cmd_t),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk),
    .rst_ni  (cptra_rst_b),
    .push_i  (cmd_valid && !fifo_full),
    .wdata_i (cmd_in),
    .pop_i   (fifo_pop),
    .rdata_o (cmd_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pauser_d = pauser_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tout_d   = tout_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          paddr_d  = cmd_head.addr;
          pwrite_d = cmd_head.write;
          pwdata_d = cmd_head.wdata;
          pauser_d = cmd_head.user;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PREADY wins over a timeout that would fire in the same cycle.
        if (pready) begin
          rdata_d = pwrite_q ? '0 : prdata;
          err_d   = pslverr;
          tout_d  = 1'b0;
          state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          tmo_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pauser_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pauser_q <= pauser_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
    end
  end

  // PSEL/PENABLE decode straight from the state register so reset drops them at once.
  assign psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable     = (state_q == ACCESS);
  assign rsp_valid   = (state_q == RESP);
  assign cmd_ready   = !fifo_full;
  assign busy        = (fifo_cnt != '0) || (state_q != IDLE);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pauser      = pauser_q;
  assign pprot       = 3'b000;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tout_q;

endmodule

// File: tb/tb_caliptra_apb_initiator.sv
module tb_caliptra_apb_initiator;

  localparam int AW = 32, DW = 32, UW = 32, DEPTH = 4, TMO = 8;

  logic          clk = 1'b0;
  logic          cptra_rst_b = 1'b0;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [UW-1:0] cmd_user = '0;
  logic          cmd_ready;
  logic          rsp_valid, rsp_err, rsp_timeout, busy;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [UW-1:0] pauser;
  logic          pready = 1'b0, pslverr = 1'b0;
  logic [DW-1:0] prdata = '0;

  always #5 clk = ~clk;

  caliptra_apb_initiator #(
    .ADDR_W(AW), .DATA_W(DW), .USER_W(UW), .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .cptra_rst_b(cptra_rst_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_user(cmd_user),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pauser(pauser), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- APB slave responder ----------------
  int          sl_wait = 0;
  logic        sl_hang = 1'b0;
  logic        sl_err  = 1'b0;
  logic [31:0] sl_rdata = '0;
  int          sl_acc = 0;

  always @(posedge clk) begin
    #1;
    if (psel && penable) sl_acc++;
    else sl_acc = 0;
    pready  = psel && penable && !sl_hang && (sl_acc == sl_wait + 1);
    prdata  = pready ? sl_rdata : 32'hBAD0_0BAD;
    pslverr = pready && sl_err;
  end

  // ---------------- Behavioural model + compare ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] user;
  } cmd_s;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_s;

  cmd_s        exp_cmd[$];
  rsp_s        exp_rsp[$];
  logic [31:0] setup_addrs[$];
  cmd_s        cur;
  int          phase_prev = 0;  // 0 none, 1 setup, 2 access, 3 transfer just ended
  int          acc_n = 0;
  int          last_acc_n = 0;
  int          setups_seen = 0;
  int          rsp_seen = 0;

  always @(negedge clk) begin : mon
    int   ph;
    cmd_s c;
    rsp_s r;
    if (!cptra_rst_b) begin
      chk("reset outputs", {psel, penable, rsp_valid, busy, rsp_err, rsp_timeout}, 0);
      chk("reset cmd_ready", cmd_ready, 1);
      exp_cmd.delete();
      exp_rsp.delete();
      phase_prev = 0;
      acc_n = 0;
    end else begin
      ph = (psel && !penable) ? 1 : (psel && penable) ? 2 : 0;
      chk("pprot", pprot, 0);
      case (phase_prev)
        1: chk("setup then access", ph, 2);
        2: chk("access held", ph, 2);
        3: begin
          chk("psel drop after end", ph, 0);
          chk("rsp_valid after end", rsp_valid, 1);
        end
        default: chk("no access without setup", (ph == 2), 0);
      endcase
      if (ph == 1) begin
        setups_seen++;
        chk("setup has queued cmd", exp_cmd.size() != 0, 1);
        if (exp_cmd.size() != 0) begin
          cur = exp_cmd.pop_front();
          chk("setup paddr", paddr, cur.addr);
          chk("setup pwrite", pwrite, cur.wr);
          chk("setup pauser", pauser, cur.user);
          if (cur.wr) chk("setup pwdata", pwdata, cur.wdata);
          setup_addrs.push_back(paddr);
        end
        acc_n = 0;
      end
      if (ph == 2) begin
        acc_n++;
        chk("access paddr", paddr, cur.addr);
        chk("access pwrite", pwrite, cur.wr);
        chk("access pauser", pauser, cur.user);
        if (cur.wr) chk("access pwdata", pwdata, cur.wdata);
        if (pready) begin
          r.rdata = cur.wr ? 32'h0 : prdata;
          r.err   = pslverr;
          r.to    = 1'b0;
          exp_rsp.push_back(r);
          last_acc_n = acc_n;
          ph = 3;
        end else if (acc_n == TMO) begin
          r.rdata = 32'h0;
          r.err   = 1'b1;
          r.to    = 1'b1;
          exp_rsp.push_back(r);
          last_acc_n = acc_n;
          ph = 3;
        end
      end
      if (rsp_valid) begin
        chk("rsp has expectation", exp_rsp.size() != 0, 1);
        if (exp_rsp.size() != 0) begin
          chk("rsp_rdata", rsp_rdata, exp_rsp[0].rdata);
          chk("rsp_err", rsp_err, exp_rsp[0].err);
          chk("rsp_timeout", rsp_timeout, exp_rsp[0].to);
          if (rsp_ready) begin
            void'(exp_rsp.pop_front());
            rsp_seen++;
          end
        end
      end
      chk("busy", busy, (exp_cmd.size() != 0) || psel || rsp_valid);
      chk("cmd_ready", cmd_ready, exp_cmd.size() != DEPTH);
      if (cmd_valid && cmd_ready) begin
        c.wr = cmd_write; c.addr = cmd_addr; c.wdata = cmd_wdata; c.user = cmd_user;
        exp_cmd.push_back(c);
      end
      phase_prev = ph;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] u);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_user = u;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) chk("push wait cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic er, output logic to);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!rsp_valid) chk("rsp wait", rsp_valid, 1);
    rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || rsp_valid) && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (busy) chk("idle wait busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] rd;
    logic        er, to;
    int          snap;
    tick(3);
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst flags", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, busy}, 0);
    chk("rst paddr", paddr, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    cptra_rst_b = 1'b1;
    tick(2);

    // Single zero-wait write, cycle-exact latency.
    sl_wait = 0; sl_err = 0; sl_hang = 0; sl_rdata = 32'hAAAA_5555; rsp_ready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h3003_0000; cmd_wdata = 32'hDEAD_BEEF;
    cmd_user = 32'h0000_0001;
    @(posedge clk);  // edge N
    #1 cmd_valid = 0;
    @(negedge clk); chk("t1 cycle N psel", psel, 0);
    @(negedge clk); chk("t1 N+1 psel/penable", {psel, penable}, 2'b10);
    chk("t1 N+1 paddr", paddr, 32'h3003_0000);
    chk("t1 N+1 pwdata", pwdata, 32'hDEAD_BEEF);
    @(negedge clk); chk("t1 N+2 psel/penable", {psel, penable}, 2'b11);
    @(negedge clk); chk("t1 N+3 rsp_valid", rsp_valid, 1);
    chk("t1 rsp_err", rsp_err, 0);
    chk("t1 rsp_rdata", rsp_rdata, 32'h0);
    chk("t1 N+3 psel", psel, 0);
    @(posedge clk); #1;
    wait_idle();

    // Read with 3 wait states.
    sl_wait = 3; sl_rdata = 32'h1234_5678;
    push(1'b0, 32'h3003_0010, 32'h0, 32'h0000_0002);
    wait_rsp(rd, er, to);
    chk("t2 rdata", rd, 32'h1234_5678);
    chk("t2 err/to", {er, to}, 2'b00);
    chk("t2 access cycles", last_acc_n, 4);
    wait_idle();

    // PSLVERR on a read.
    sl_wait = 0; sl_err = 1; sl_rdata = 32'hCAFE_F00D;
    push(1'b0, 32'h3003_0020, 32'h0, 32'h0000_0003);
    wait_rsp(rd, er, to);
    chk("t3 err/to", {er, to}, 2'b10);
    chk("t3 rdata", rd, 32'hCAFE_F00D);
    sl_err = 0;
    wait_idle();

    // Timeout with PREADY held low.
    sl_hang = 1;
    push(1'b0, 32'h3003_0030, 32'h0, 32'h0000_0004);
    wait_rsp(rd, er, to);
    chk("t4 access cycles", last_acc_n, TMO);
    chk("t4 err/to", {er, to}, 2'b11);
    chk("t4 rdata", rd, 32'h0);
    chk("t4 psel dropped", psel, 0);
    sl_hang = 0;
    wait_idle();

    // FIFO full under response backpressure, then drain in order.
    rsp_ready = 0; sl_wait = 0;
    setup_addrs.delete();
    snap = rsp_seen;
    for (int i = 0; i < 5; i++) push(1'b1, 32'h3003_0100 + 32'(4 * i), 32'(i), 32'h5);
    @(negedge clk);
    chk("t5 cmd_ready full", cmd_ready, 0);
    chk("t5 rsp pending", rsp_valid, 1);
    chk("t5 busy", busy, 1);
    tick(3);
    @(negedge clk);
    chk("t5 still full", cmd_ready, 0);
    chk("t5 one setup only", setup_addrs.size(), 1);
    @(posedge clk); #1;
    rsp_ready = 1;
    wait_idle();
    chk("t5 responses", rsp_seen - snap, 5);
    chk("t5 transfers", setup_addrs.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < setup_addrs.size()) chk("t5 order", setup_addrs[i], 32'h3003_0100 + 32'(4 * i));

    // Reset in the middle of ACCESS with two commands still queued.
    sl_wait = 6;
    for (int i = 0; i < 3; i++) push(1'b0, 32'h3003_0200 + 32'(4 * i), 32'h0, 32'h6);
    chk("t6 in access", {psel, penable}, 2'b11);
    chk("t6 busy before reset", busy, 1);
    #2 cptra_rst_b = 1'b0;
    #1;
    chk("t6 psel/penable", {psel, penable}, 2'b00);
    chk("t6 rsp_valid", rsp_valid, 0);
    chk("t6 busy", busy, 0);
    chk("t6 cmd_ready", cmd_ready, 1);
    snap = setups_seen;
    tick(2);
    cptra_rst_b = 1'b1;
    tick(20);
    chk("t6 no transfer after release", setups_seen - snap, 0);
    chk("t6 busy after release", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/caliptra_apb_initiator.md
Name: caliptra_apb_initiator

Overview:
- RTL APB requester (master) that drives the Caliptra SoC-facing APB slave port (PADDR/PSEL/PENABLE/PWRITE/PWDATA/PAUSER in, PRDATA/PREADY/PSLVERR out).
- Accepts queued read/write commands over a valid/ready interface and executes them as APB transfers. Returns read data and error status over a valid/ready response interface.
- Replaces per-signal C++ APB bit-banging in the verilated harness and in standalone benches.
- Includes a bounded PREADY-wait timeout so a hung slave cannot stall the harness.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- USER_W, 32, PAUSER width.
- CMD_DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before the transfer is aborted; at least 1.

Ports:
- clk  in  1  core clock.
- cptra_rst_b  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- cmd_user  in  USER_W  PAUSER value for this transfer.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  captured PRDATA; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR sampled with PREADY, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- paddr  out  ADDR_W  APB PADDR.
- pprot  out  3  tied to 3'b000.
- psel  out  1  APB PSEL.
- penable  out  1  APB PENABLE.
- pwrite  out  1  APB PWRITE.
- pwdata  out  DATA_W  APB PWDATA.
- pauser  out  USER_W  APB PAUSER.
- pready  in  1  APB PREADY.
- prdata  in  DATA_W  APB PRDATA.
- pslverr  in  1  APB PSLVERR.

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. FIFO empty, FSM in IDLE, timeout counter 0.
- Asserting reset mid-transfer drops psel/penable immediately and discards all queued commands. No response is emitted for them.
- Command FIFO: push when cmd_valid && cmd_ready. cmd_ready = (count != CMD_DEPTH).
  - Pointers wrap modulo CMD_DEPTH; count width is $clog2(CMD_DEPTH+1).
  - Simultaneous push and pop is legal whenever not full; count is unchanged in that case.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if the FIFO is non-empty, pop the head and load the APB output registers; go to SETUP.
- SETUP: psel = 1, penable = 0, with paddr/pwrite/pwdata/pauser valid. Unconditionally go to ACCESS.
- ACCESS: psel = 1, penable = 1. All APB outputs are held stable. The counter increments each cycle without PREADY.
  - pready = 1: capture prdata (reads only; writes capture 0) and pslverr into rsp_*. Drop psel/penable on the next edge and go to RESP.
  - counter reaches TIMEOUT_CYCLES - 1 without pready: rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. Drop psel/penable and go to RESP.
  - PREADY arriving in the same cycle the timeout would fire counts as a normal completion.
- RESP: rsp_valid = 1 and rsp_* held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE and clear rsp_valid and the counter.
  - No new transfer starts while a response is pending. At most one transfer is outstanding.
- Latency: command pushed at edge N -> SETUP in cycle N+1 -> ACCESS in N+2. With zero-wait PREADY, rsp_valid is high from N+3.
  - Minimum spacing is 4 cycles per transfer, with rsp_ready held high.
- psel never deasserts during ACCESS except on completion or timeout. PENABLE never rises without a prior SETUP cycle.

Decomposition:
- Package caliptra_apb_initiator_pkg:
  - apb_init_state_e (IDLE/SETUP/ACCESS/RESP).
  - apb_cmd_t struct {write, addr, wdata, user}, parameterised through localparams matching the Caliptra APB width defines.
- Sub-module caliptra_apb_cmd_fifo: a synchronous FIFO of apb_cmd_t with push/pop/full/empty/count. It is reusable by the mailbox stimulus path.

Test Plan:
- Single write: cmd addr 0x3003_0000, wdata 0xDEAD_BEEF, zero-wait PREADY.
  - Required: psel rises at N+1, penable at N+2, rsp_valid at N+3, rsp_err = 0, rsp_rdata = 0.
- Read with 3 wait states: prdata = 0x1234_5678 presented with pready on the 4th ACCESS cycle.
  - Required: PADDR/PWRITE held stable throughout, rsp_rdata = 0x1234_5678.
- PSLVERR: read returns pslverr = 1 with pready.
  - Required: rsp_err = 1, rsp_timeout = 0.
- Timeout: TIMEOUT_CYCLES = 8, pready held at 0.
  - Required: exactly 8 ACCESS cycles, then psel drops, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- FIFO full and backpressure: push 5 commands with CMD_DEPTH = 4 and rsp_ready = 0.
  - Required: cmd_ready = 0 after 4 entries while the first transfer sits in RESP.
  - Required: then draining issues all commands in order with matching addresses.
- Reset mid-ACCESS: drop cptra_rst_b with 2 commands queued.
  - Required: psel = 0 immediately, rsp_valid = 0, busy = 0, and no transfer after release.
